rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 32 +++
 rtl/rf_wb_arbiter_wb_fifo.sv | 57 +++++
 rtl/rf_wb_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Provides the build-wide defaults WIDTH, RF_ADD_SIZE, LQ_DEPTH and STARVE_LIMIT as macros
// (overridable on the command line) plus the grant encoding used by rf_wb_arbiter.
// Optional feature macro (consumed in rf_wb_arbiter.sv): WB_FWD_EN.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef RF_ADD_SIZE
`define RF_ADD_SIZE 5
`endif
`ifndef LQ_DEPTH
`define LQ_DEPTH 4
`endif
`ifndef STARVE_LIMIT
`define STARVE_LIMIT 8
`endif

package rf_wb_arbiter_pkg;

    localparam int unsigned WB_WIDTH        = `WIDTH;
    localparam int unsigned WB_ADDR         = `RF_ADD_SIZE;
    localparam int unsigned WB_LQ_DEPTH     = `LQ_DEPTH;
    localparam int unsigned WB_STARVE_LIMIT = `STARVE_LIMIT;

    // Which source owns the write port this cycle
    typedef enum logic [1:0] {
        GntNone = 2'd0,
        GntAlu  = 2'd1,
        GntLd   = 2'd2
    } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// wb_fifo: small FIFO holding pending load write-backs ({rd, data} payload).
// Exposes the registered occupancy so the producer-side ready can be derived without
// any combinational path from the consumer.
module wb_fifo #(
    parameter int unsigned DW    = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_data,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = PTRW + 1;

    logic [DW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wptr_q, rptr_q;
    logic [CNTW-1:0] count_q;

    // Storage array; contents are don't-care while count is zero, so no reset needed
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem[wptr_q] <= i_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (i_push) begin
                wptr_q <= wptr_q + PTRW'(1);
            end
            if (i_pop) begin
                rptr_q <= rptr_q + PTRW'(1);
            end
            unique case ({i_push, i_pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_data  = mem[rptr_q];
    assign o_count = count_q;
    assign o_empty = (count_q == '0);

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges single-cycle ALU results and queued load results onto the one
// register-file write port. ALU wins by default; a load that has waited STARVE_LIMIT
// cycles is forced through and the ALU is stalled for that cycle.
// Optional feature macro: WB_FWD_EN enables the decode-stage bypass comparators;
// without it the bypass outputs are tied to zero.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH        = `WIDTH,
    parameter int unsigned ADDR         = `RF_ADD_SIZE,
    parameter int unsigned LQ_DEPTH     = `LQ_DEPTH,
    parameter int unsigned STARVE_LIMIT = `STARVE_LIMIT
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_alu_valid,
    input  logic [ADDR-1:0]  i_alu_rd,
    input  logic [WIDTH-1:0] i_alu_data,
    output logic             o_alu_stall,
    input  logic             i_ld_valid,
    output logic             o_ld_ready,
    input  logic [ADDR-1:0]  i_ld_rd,
    input  logic [WIDTH-1:0] i_ld_data,
    output logic             o_rf_w,
    output logic [ADDR-1:0]  o_rf_dst,
    output logic [WIDTH-1:0] o_rf_data,
    input  logic [ADDR-1:0]  i_src_0,
    input  logic [ADDR-1:0]  i_src_1,
    output logic             o_fwd_hit_0,
    output logic             o_fwd_hit_1,
    output logic [WIDTH-1:0] o_fwd_data_0,
    output logic [WIDTH-1:0] o_fwd_data_1
);

    localparam int unsigned PW = WIDTH + ADDR;
    localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0]    lq_head;
    logic [CW-1:0]    lq_count;
    logic             lq_empty;
    logic             lq_push, lq_pop;
    logic             alu_ok, starve_hit;
    logic [SW-1:0]    starve_q, starve_d;
    grant_e           grant;
    logic             rf_w_q;
    logic [ADDR-1:0]  rf_dst_q;
    logic [WIDTH-1:0] rf_data_q;

    // x0 writes are architecturally void, so they never compete for the port
    assign alu_ok     = i_alu_valid && (i_alu_rd != '0);
    assign starve_hit = !lq_empty && (starve_q == SW'(STARVE_LIMIT));
    assign o_alu_stall = alu_ok && starve_hit;
    // Ready depends only on registered occupancy: no same-cycle enqueue when full
    assign o_ld_ready = (lq_count < CW'(LQ_DEPTH));
    assign lq_push    = i_ld_valid && o_ld_ready && (i_ld_rd != '0);
    assign lq_pop     = (grant == GntLd);

    // Grant priority: starving load, then ALU, then any queued load
    always_comb begin
        grant = GntNone;
        if (starve_hit) begin
            grant = GntLd;
        end else if (alu_ok) begin
            grant = GntAlu;
        end else if (!lq_empty) begin
            grant = GntLd;
        end
    end

    // Starve counter: clears on head grant or empty queue, otherwise saturating increment
    always_comb begin
        starve_d = starve_q;
        if (lq_empty || lq_pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    wb_fifo #(
        .DW    (PW),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (lq_push),
        .i_data  ({i_ld_rd, i_ld_data}),
        .i_pop   (lq_pop),
        .o_data  (lq_head),
        .o_count (lq_count),
        .o_empty (lq_empty)
    );

    // Starve counter state
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Registered write port; dst/data hold their last value between writes
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rf_w_q    <= 1'b0;
            rf_dst_q  <= '0;
            rf_data_q <= '0;
        end else begin
            rf_w_q <= (grant != GntNone);
            if (grant == GntAlu) begin
                rf_dst_q  <= i_alu_rd;
                rf_data_q <= i_alu_data;
            end else if (grant == GntLd) begin
                rf_dst_q  <= lq_head[PW-1:WIDTH];
                rf_data_q <= lq_head[WIDTH-1:0];
            end
        end
    end

    assign o_rf_w    = rf_w_q;
    assign o_rf_dst  = rf_dst_q;
    assign o_rf_data = rf_data_q;

`ifdef WB_FWD_EN
    assign o_fwd_hit_0  = rf_w_q && (rf_dst_q == i_src_0) && (i_src_0 != '0);
    assign o_fwd_hit_1  = rf_w_q && (rf_dst_q == i_src_1) && (i_src_1 != '0);
    assign o_fwd_data_0 = o_fwd_hit_0 ? rf_data_q : '0;
    assign o_fwd_data_1 = o_fwd_hit_1 ? rf_data_q : '0;
`else
    logic unused_src;
    assign unused_src   = ^{i_src_0, i_src_1};
    assign o_fwd_hit_0  = 1'b0;
    assign o_fwd_hit_1  = 1'b0;
    assign o_fwd_data_0 = '0;
    assign o_fwd_data_1 = '0;
`endif

endmodule
